// File: rtl/solver_run_monitor_pkg.sv
// solver_pkg: shared types and helpers for the solver run monitor.
//   state_t    run-controller states
//   img_words  number of legal memory words for an image of rows x cols
package solver_pkg;
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
    function automatic int img_words(input int rows, input int cols);
        return rows * cols;
    endfunction
endpackage

// File: rtl/solver_run_monitor_if.sv
// solver_run_monitor_if: solver-side signals between the run monitor and waffle_solver/memory.
//   master (monitor): drives solver_rst; observes complete, result, we, addr1, addr2
//   slave  (solver) : receives solver_rst; drives complete, result, we, addr1, addr2
interface solver_run_monitor_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
    logic              solver_rst;
    logic              complete;
    logic [DATA_W-1:0] result;
    logic              we;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    modport master (output solver_rst, input complete, result, we, addr1, addr2);
    modport slave  (input solver_rst, output complete, result, we, addr1, addr2);
endinterface

// File: rtl/solver_run_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst  clock, sync active-high reset
//   clear     zero the count
//   inc       add one unless already at all-ones
//   q         count
module sat_counter #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (rst || clear) ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/solver_run_monitor.sv
// solver_run_monitor: sequences one waffle_solver run per start pulse and reports its outcome.
//   clk, rst                 clock, sync active-high reset
//   start, check_en, expected host run request and golden result
//   sif (master)             solver reset out; complete/result/memory snoop in
//   busy, done, pass, timeout, addr_err   run status (registered)
//   cycle_count, write_count, result_q    run statistics and captured result
module solver_run_monitor
    import solver_pkg::*;
#(
    parameter int IMG_ROWS   = 32,
    parameter int IMG_COLS   = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 check_en,
    input  logic [DATA_W-1:0]    expected,
    solver_run_monitor_if.master sif,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     write_count,
    output logic [DATA_W-1:0]    result_q
);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    // One extra bit so the word count never truncates against a full-width address.
    localparam logic [ADDR_W:0] WORDS = (ADDR_W + 1)'(img_words(IMG_ROWS, IMG_COLS));
    state_t         state;
    logic [RCW-1:0] rst_cnt;
    logic           start_ok, in_run, at_limit, bad_addr, addr_err_next;
    assign start_ok      = start && (state == IDLE || state == DONE);
    assign in_run        = state == RUN;
    // The limit cycle is the one that brings cycle_count up to MAX_CYCLES.
    assign at_limit      = cycle_count == CNT_W'(MAX_CYCLES - 1);
    assign bad_addr      = ({1'b0, sif.addr1} >= WORDS) || ({1'b0, sif.addr2} >= WORDS);
    assign addr_err_next = addr_err || (in_run && bad_addr);
    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(in_run), .q(cycle_count)
    );
    sat_counter #(.W(CNT_W)) u_writes (
        .clk(clk), .rst(rst), .clear(start_ok), .inc(in_run && sif.we), .q(write_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rst_cnt        <= '0;
            sif.solver_rst <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            addr_err       <= 1'b0;
            result_q       <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= RESET;
                    rst_cnt  <= RCW'(RST_CYCLES - 1);
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                    timeout  <= 1'b0;
                    addr_err <= 1'b0;
                    result_q <= '0;
                end
                RESET: if (rst_cnt == '0) begin
                    state          <= RUN;
                    sif.solver_rst <= 1'b0;
                end else begin
                    rst_cnt <= rst_cnt - 1'b1;
                end
                RUN: begin
                    addr_err <= addr_err_next;
                    // complete beats the limit when both land on the same cycle.
                    if (sif.complete || at_limit) begin
                        state          <= DONE;
                        sif.solver_rst <= 1'b1;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        timeout        <= !sif.complete;
                        pass           <= sif.complete && !addr_err_next &&
                                          (!check_en || sif.result == expected);
                        if (sif.complete) result_q <= sif.result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_solver_run_monitor.sv
// tb_solver_run_monitor: scoreboard bench for solver_run_monitor (RST_CYCLES=2, MAX_CYCLES=100, 32x32).
module tb_solver_run_monitor;
    localparam int MAXC = 100;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, check_en = 1'b0;
    logic [31:0] expected = '0;
    logic        busy, done, pass, timeout, addr_err;
    logic [31:0] cycle_count, write_count, result_q;
    int          vectors = 0, errors = 0;
    typedef struct {
        longint cyc, wr, res;
        bit     pass, tmo, aerr;
    } exp_t;
    exp_t sb[$];
    solver_run_monitor_if #(.DATA_W(32), .ADDR_W(32)) sif ();
    solver_run_monitor #(
        .IMG_ROWS(32), .IMG_COLS(32), .DATA_W(32), .ADDR_W(32), .CNT_W(32),
        .RST_CYCLES(2), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .check_en(check_en), .expected(expected),
        .sif(sif), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .addr_err(addr_err), .cycle_count(cycle_count), .write_count(write_count),
        .result_q(result_q)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic idle_inputs();
        sif.complete = 1'b0;
        sif.we       = 1'b0;
        sif.addr1    = '0;
        sif.addr2    = '0;
        sif.result   = '0;
        start        = 1'b0;
    endtask
    // n: RUN cycle that asserts complete (0 = never); bad: RUN cycle with addr1=1024 (0 = none);
    // nwe: we high on the first nwe RUN cycles; mid: RUN cycle carrying a stray start (0 = none).
    task automatic run(input int n, input logic [31:0] res, input logic [31:0] exp_v,
                       input bit ce, input int bad, input int nwe, input int mid);
        exp_t e;
        bit   comp;
        int   lim, rs, cyc;
        longint wr0;
        comp   = n >= 1 && n <= MAXC;
        lim    = comp ? n : MAXC;
        e.cyc  = lim;
        e.wr   = nwe < lim ? nwe : lim;
        e.aerr = bad >= 1 && bad <= lim;
        e.tmo  = !comp;
        e.pass = comp && !e.aerr && (!ce || res == exp_v);
        e.res  = comp ? res : 0;
        sb.push_back(e);
        check_en = ce;
        expected = exp_v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("count_cleared", cycle_count, 0);
        rs = 0;
        while (sif.solver_rst && rs < 10) begin
            rs++;
            @(negedge clk);
        end
        chk("solver_rst_len", rs, 2);
        cyc = 1;
        while (!done && cyc <= 2 * MAXC) begin
            sif.complete = cyc == n;
            sif.we       = cyc <= nwe;
            sif.addr1    = cyc == bad ? 32'd1024 : 32'(cyc);
            sif.addr2    = 32'(1023 - cyc);
            sif.result   = cyc == n ? res : 32'hdead_beef;
            start        = cyc == mid;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        chk("run_len", cyc - 1, lim);
        chk("done", done, 1);
        chk("busy_off", busy, 0);
        chk("solver_rst_done", sif.solver_rst, 1);
        e = sb.pop_front();
        chk("cycle_count", cycle_count, e.cyc);
        chk("write_count", write_count, e.wr);
        chk("addr_err", addr_err, e.aerr);
        chk("timeout", timeout, e.tmo);
        chk("pass", pass, e.pass);
        chk("result_q", result_q, e.res);
        // Snoop inputs must be ignored once DONE.
        wr0       = write_count;
        sif.we    = 1'b1;
        sif.addr1 = 32'd5000;
        repeat (3) @(negedge clk);
        idle_inputs();
        chk("done_hold_wr", write_count, wr0);
        chk("done_hold_aerr", addr_err, e.aerr);
        chk("done_sticky", done, 1);
    endtask
    initial begin
        int k;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_solver_rst", sif.solver_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_write_count", write_count, 0);
        chk("rst_result_q", result_q, 0);
        run(50, 7, 7, 1, 0, 0, 0);
        run(50, 7, 8, 1, 0, 0, 0);
        run(50, 7, 8, 0, 0, 0, 0);
        run(0, 7, 7, 1, 0, 3, 0);
        run(50, 7, 7, 1, 10, 5, 0);
        run(50, 9, 9, 1, 0, 60, 10);
        run(MAXC, 11, 11, 1, 0, 0, 0);
        // Reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (sif.solver_rst && k < 10) begin
            k++;
            @(negedge clk);
        end
        for (int i = 1; i <= 20; i++) begin
            sif.we    = 1'b1;
            sif.addr1 = i == 5 ? 32'd2000 : 32'd1;
            if (i == 20) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        idle_inputs();
        chk("abort_solver_rst", sif.solver_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr_err", addr_err, 0);
        chk("abort_cycle_count", cycle_count, 0);
        chk("abort_write_count", write_count, 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        run(30, 3, 3, 1, 0, 2, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
